sync_bin_count_mod: RTL
=======================

// Module: sync_bin_count_mod
// PURPOSE
//  Parametrised synchronous up/down/load binary counter with programmable modulus.
//  Supports wrap or saturate mode, a one-cycle terminal-count pulse and a sticky
//  overflow/underflow flag. Optional enable prescaler.
//  Drop-in successor for the 4-bit up/down/load counter in timer, divider and
//  event-count paths.
// PARAMETERS
//  NBITS      4   counter, data and max_val width (>=2)
//  PRESC_DIV  4   prescaler division ratio (>=1); used only with SYNC_CNT_PRESCALE_EN
// PORTS
//  clk       in   1      clock, rising edge
//  rst       in   1      asynchronous reset, active-high
//  ena       in   1      count enable
//  load      in   1      synchronous load of data; independent of ena
//  data      in   NBITS  load value
//  up_dwn    in   1      1 = count up, 0 = count down
//  mode_sat  in   1      0 = wrap at modulus, 1 = saturate at bounds
//  max_val   in   NBITS  terminal value; count range is 0..max_val
//  clr_flag  in   1      synchronous clear of ovf
//  counter   out  NBITS  registered count value
//  tc        out  1      registered terminal-count pulse, one cycle wide
//  ovf       out  1      sticky saturation flag (overflow or underflow)
//  zero      out  1      combinational: counter == 0
// BEHAVIOUR
//  - Reset: rst=1 forces counter=0, tc=0, ovf=0 and the prescaler to 0, all
//    asynchronously. On release, the first update occurs on the next rising edge.
//  - Priority per edge: rst > load > count > hold. Any update is visible one
//    clk after the sampling edge.
//  - Load: counter <= min(data, max_val). The load cycle drives tc=0 and leaves
//    ovf unchanged.
//  - Count step: occurs when ena=1 and tick=1 and load=0.
//    - Up, counter <  max_val: counter+1.
//    - Up, counter >= max_val, wrap mode: counter <= 0; tc=1 next cycle.
//    - Up, counter >= max_val, saturate mode: counter <= max_val; ovf <= 1; tc=0.
//    - Down, counter > max_val: counter <= max_val. This covers max_val being
//      lowered mid-count.
//    - Down, counter == 0, wrap mode: counter <= max_val; tc=1.
//    - Down, counter == 0, saturate mode: hold 0; ovf <= 1.
//    - Down, otherwise: counter-1.
//  - tc is 0 on every cycle without a wrap step. Back-to-back wraps give
//    back-to-back tc pulses.
//  - max_val=0: counter stays at 0. In wrap mode tc=1 after every count step.
//    In saturate mode ovf sets on the first step.
//  - ovf: set and clr_flag on the same edge -> set wins. ovf is never cleared
//    by load.
//  - up_dwn, mode_sat and max_val are sampled every edge with no internal
//    state; direction reversal takes effect on the next step.
//  - All arithmetic is NBITS unsigned. No carry is exported.
// CONFIGURATION
//  - SYNC_CNT_PRESCALE_EN defined:
//    - tick comes from a prescaler that counts ena=1 cycles 0..PRESC_DIV-1 and
//      asserts tick on PRESC_DIV-1 (one step per PRESC_DIV enabled cycles).
//    - load or rst returns the prescaler to 0.
//  - SYNC_CNT_PRESCALE_EN undefined: tick is constant 1, PRESC_DIV is ignored,
//    and no prescaler flops are built.
// STRUCTURE
//  - Package sync_cnt_pkg holds:
//    - dir_e {DN=0, UP=1} and mode_e {WRAP=0, SAT=1};
//    - function clamp(data, max_val).
//  - Sub-module sync_cnt_prescaler (params PRESC_DIV; ports clk, rst, ena,
//    clr, tick) is instantiated only under SYNC_CNT_PRESCALE_EN.
//  - Core: one next-state always_comb, one async-reset always_ff for counter,
//    tc and ovf.
// TESTING
//  1. NBITS=4, max_val=9, wrap, up, ena=1 for 12 cycles from reset
//     -> 0..9,0,1; tc=1 only with the first 0 after 9.
//  2. max_val=9, down, wrap from 0 -> 9,8,...; tc=1 with the 9; zero=1 at start.
//  3. Saturate, up, load data=15 with max_val=9 -> counter=9.
//     Next step: holds 9, ovf=1. clr_flag -> ovf=0.
//     clr_flag together with a saturating step -> ovf stays 1.
//  4. Counting up at 7, assert rst for half a cycle asynchronously
//     -> counter=0, tc=0 immediately. Counting resumes 1,2 after release.
//  5. At 8 with max_val=9: assert load=1, ena=0, data=3 -> counter=3.
//     Then set max_val=2, counting down -> next value 2.
//  6. With SYNC_CNT_PRESCALE_EN, PRESC_DIV=4, up, ena=1 for 12 cycles
//     -> counter 0 to 3, one step every 4 cycles. A mid-run load restarts
//     the 4-cycle spacing.

Source files
------------

// File: rtl/sync_cnt_pkg.sv
// Shared types and helpers for the up/down/load counter and its prescaler.
// No logic state lives here.
package sync_cnt_pkg;

    typedef enum logic {DN = 1'b0, UP  = 1'b1} dir_e;
    typedef enum logic {WRAP = 1'b0, SAT = 1'b1} mode_e;

    // Widest counter the helper supports; callers extend into and truncate out of it.
    localparam int CNT_MAX_W = 64;

    function automatic logic [CNT_MAX_W-1:0] clamp(input logic [CNT_MAX_W-1:0] data,
                                                   input logic [CNT_MAX_W-1:0] max_val);
        return (data > max_val) ? max_val : data;
    endfunction

endpackage

// File: rtl/sync_cnt_prescaler.sv
// Enable prescaler: tick is high on every PRESC_DIV-th enabled cycle (combinational from state).
// One-cycle update latency; clr (load) restarts the spacing, no backpressure.
module sync_cnt_prescaler #(
    parameter int PRESC_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic clr,
    output logic tick
);

    localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESC_DIV - 1);

    logic [PW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ena) begin
            cnt <= tick ? '0 : cnt + PW'(1);
        end
    end

endmodule

// File: rtl/sync_bin_count_mod.sv
// Up/down/load counter with programmable modulus, wrap/saturate, tc pulse and sticky ovf.
// One-cycle update latency; no backpressure. Optional prescaler: SYNC_CNT_PRESCALE_EN.
module sync_bin_count_mod
    import sync_cnt_pkg::*;
#(
    parameter int NBITS     = 4,
    parameter int PRESC_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             load,
    input  logic [NBITS-1:0] data,
    input  logic             up_dwn,
    input  logic             mode_sat,
    input  logic [NBITS-1:0] max_val,
    input  logic             clr_flag,
    output logic [NBITS-1:0] counter,
    output logic             tc,
    output logic             ovf,
    output logic             zero
);

    if (NBITS < 2 || NBITS > CNT_MAX_W) begin : g_bad_nbits
        $error("sync_bin_count_mod: NBITS out of range");
    end
    if (PRESC_DIV < 1) begin : g_bad_div
        $error("sync_bin_count_mod: PRESC_DIV must be >= 1");
    end

    logic tick;

`ifdef SYNC_CNT_PRESCALE_EN
    sync_cnt_prescaler #(
        .PRESC_DIV (PRESC_DIV)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .clr  (load),
        .tick (tick)
    );
`else
    assign tick = 1'b1;
`endif

    dir_e             dir;
    mode_e            mode;
    logic [NBITS-1:0] load_val;
    logic [NBITS-1:0] cnt_nxt;
    logic             tc_nxt;
    logic             ovf_nxt;

    assign dir      = dir_e'(up_dwn);
    assign mode     = mode_e'(mode_sat);
    assign load_val = NBITS'(clamp(CNT_MAX_W'(data), CNT_MAX_W'(max_val)));
    assign zero     = (counter == '0);

    always_comb begin
        cnt_nxt = counter;
        tc_nxt  = 1'b0;
        ovf_nxt = ovf;
        if (clr_flag) begin
            ovf_nxt = 1'b0;
        end
        if (load) begin
            cnt_nxt = load_val;
        end else if (ena && tick) begin
            if (dir == UP) begin
                if (counter >= max_val) begin
                    if (mode == SAT) begin
                        cnt_nxt = max_val;
                        ovf_nxt = 1'b1;
                    end else begin
                        cnt_nxt = '0;
                        tc_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt = counter + NBITS'(1);
                end
            end else begin
                // Above the modulus (max_val lowered mid-count): snap down to it.
                if (counter > max_val) begin
                    cnt_nxt = max_val;
                end else if (counter == '0) begin
                    if (mode == SAT) begin
                        ovf_nxt = 1'b1;
                    end else begin
                        cnt_nxt = max_val;
                        tc_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt = counter - NBITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= '0;
            tc      <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            counter <= cnt_nxt;
            tc      <= tc_nxt;
            ovf     <= ovf_nxt;
        end
    end

endmodule
